// File: rtl/ysyx_22050019_icache_pkg.sv
// ysyx_22050019_icache_pkg: shared widths, response codes and responder states
package ysyx_22050019_icache_pkg;
  localparam int LINE_W = 128;
  localparam int BEAT_W = 64;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, RESP} state_t;
endpackage

// File: rtl/ysyx_22050019_icache_line_array.sv
// ysyx_22050019_icache_line_array: direct-mapped tag/valid/data store with async read, sync write and flush-all
module ysyx_22050019_icache_line_array
  import ysyx_22050019_icache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 28 - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [LINE_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] data [LINES];
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINES-1:0]  valid;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (we) begin
      data[widx] <= wdata;
      tags[widx] <= wtag;
    end
  end
  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = data[ridx];
endmodule

// File: rtl/ysyx_22050019_icache_line_responder.sv
// ysyx_22050019_icache_line_responder: AXI-style 128-bit line read responder with two-beat refill
module ysyx_22050019_icache_line_responder
  import ysyx_22050019_icache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ar_valid_i,
  output logic              ar_ready_o,
  input  logic [31:0]       ar_addr_i,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic [LINE_W-1:0] r_data_o,
  output logic [1:0]        r_resp_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [BEAT_W-1:0] mem_rdata_i,
  input  logic              mem_rerr_i
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;
  state_t state, state_n;
  logic [27:0]       addr;
  logic              beat, err, flushed;
  logic [BEAT_W-1:0] lo;
  logic [LINE_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_data;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              accept, hit, fill, last, err_n, we;
  assign idx    = addr[IDX_W-1:0];
  assign tag    = addr[27:IDX_W];
  assign accept = state == IDLE && ar_valid_i;
  assign hit    = arr_valid && arr_tag == tag;
  assign fill   = state == WAIT && mem_rvalid_i;
  assign last   = fill && beat;
  assign err_n  = err | mem_rerr_i;
  assign we     = last && !err_n && !flushed;
  ysyx_22050019_icache_line_array #(
    .LINES(LINES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_i),
    .we    (we),
    .widx  (idx),
    .wtag  (tag),
    .wdata ({mem_rdata_i, lo}),
    .ridx  (idx),
    .rvalid(arr_valid),
    .rtag  (arr_tag),
    .rdata (arr_data)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = ar_valid_i ? LOOKUP : IDLE;
      LOOKUP:  state_n = hit ? RESP : REQ;
      REQ:     state_n = mem_ready_i ? WAIT : REQ;
      WAIT:    state_n = mem_rvalid_i ? (beat ? RESP : REQ) : WAIT;
      RESP:    state_n = r_ready_i ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      beat    <= 1'b0;
      err     <= 1'b0;
      flushed <= 1'b0;
      lo      <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      state <= state_n;
      if (accept) begin
        addr    <= ar_addr_i[31:4];
        beat    <= 1'b0;
        err     <= 1'b0;
        flushed <= 1'b0;
      end else if (flush_i) begin
        flushed <= 1'b1;
      end
      if (state == LOOKUP && hit) begin
        r_data <= arr_data;
        r_resp <= RESP_OKAY;
      end
      if (fill) begin
        err  <= err_n;
        beat <= 1'b1;
        if (!beat) lo <= mem_rdata_i;
      end
      if (last) begin
        r_data <= {mem_rdata_i, lo};
        r_resp <= err_n ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
  assign ar_ready_o = rst_n && state == IDLE;
  assign r_valid_o  = rst_n && state == RESP;
  assign mem_req_o  = rst_n && state == REQ;
  assign mem_addr_o = mem_req_o ? {addr, beat, 3'b000} : '0;
  assign r_data_o   = rst_n ? r_data : '0;
  assign r_resp_o   = rst_n ? r_resp : RESP_OKAY;
endmodule

// File: tb/tb_ysyx_22050019_icache_line_responder.sv
// tb_ysyx_22050019_icache_line_responder: table-driven scoreboard bench with a behavioural two-beat memory
module tb_ysyx_22050019_icache_line_responder;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         ar_valid_i = 0;
  logic         ar_ready_o;
  logic [31:0]  ar_addr_i = 0;
  logic         r_valid_o;
  logic         r_ready_i = 0;
  logic [127:0] r_data_o;
  logic [1:0]   r_resp_o;
  logic         flush_i;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ready_i = 0;
  logic         mem_rvalid_i;
  logic [63:0]  mem_rdata_i;
  logic         mem_rerr_i = 0;
  logic         flush_t = 0, flush_m = 0;
  logic         rv_m = 0, rv_t = 0;
  logic [63:0]  data_m = 0;
  assign flush_i      = flush_t | flush_m;
  assign mem_rvalid_i = rv_m | rv_t;
  assign mem_rdata_i  = rv_t ? 64'hdead_beef_dead_beef : data_m;
  ysyx_22050019_icache_line_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ar_valid_i  (ar_valid_i),
    .ar_ready_o  (ar_ready_o),
    .ar_addr_i   (ar_addr_i),
    .r_valid_o   (r_valid_o),
    .r_ready_i   (r_ready_i),
    .r_data_o    (r_data_o),
    .r_resp_o    (r_resp_o),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ready_i (mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_rerr_i  (mem_rerr_i)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    int          err_beat;
    int          flush_mode;
    bit          miss;
    logic [1:0]  resp;
    int          bp;
  } vec_t;
  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
    int           beats;
  } exp_t;
  vec_t        tbl[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          beats = 0;
  int          err_beat = 0;
  int          flush_mode = 0;
  bit          block_mem = 0;
  logic [31:0] cur_addr = 0;
  function automatic logic [31:0] word_of(input logic [31:0] w);
    return {8{w[5:2]}} ^ {w[15:4], 20'h0};
  endfunction
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k+:32] = word_of({a[31:4], 4'h0} + 32'(4 * k));
    return l;
  endfunction
  function automatic void add(input logic [31:0] a, input int eb, input int fm, input bit m, input logic [1:0] r, input int bp);
    vec_t v;
    v.addr = a; v.err_beat = eb; v.flush_mode = fm; v.miss = m; v.resp = r; v.bp = bp;
    tbl.push_back(v);
  endfunction
  task automatic chk(input string name, input logic [130:0] act, input logic [130:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    int bb;
    logic [31:0] a0;
    forever begin
      @(negedge clk);
      if (mem_req_o && !block_mem) begin
        bb = beats;
        a0 = {cur_addr[31:4], bb[0], 3'b000};
        chk("mem_addr", mem_addr_o, a0);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("mem_req stable", {mem_req_o, mem_addr_o}, {1'b1, a0});
        end
        mem_ready_i = 1;
        @(negedge clk);
        mem_ready_i = 0;
        chk("mem_req drop", mem_req_o, 0);
        if (flush_mode == 1 && bb == 0) begin
          flush_m = 1;
          @(negedge clk);
          flush_m = 0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rv_m = 1;
        data_m = {word_of(a0 + 4), word_of(a0)};
        mem_rerr_i = err_beat == bb + 1;
        flush_m = flush_mode == 3 && bb == 1;
        beats++;
        @(negedge clk);
        rv_m = 0;
        mem_rerr_i = 0;
        flush_m = 0;
      end
    end
  end
  task automatic send_ar(input logic [31:0] a, output bit ok);
    ar_valid_i = 1;
    ar_addr_i = a;
    for (int i = 0; i < 20 && !ar_ready_o; i++) @(negedge clk);
    ok = ar_ready_o;
    if (!ok) chk("ar_ready timeout", 0, 1);
    @(negedge clk);
    ar_valid_i = 0;
  endtask
  task automatic do_req(input vec_t v);
    exp_t e;
    logic [127:0] d0;
    logic [1:0] r0;
    int lat;
    bit ok;
    if (v.flush_mode == 2) begin
      flush_t = 1;
      @(negedge clk);
      flush_t = 0;
    end
    cur_addr = v.addr;
    err_beat = v.err_beat;
    flush_mode = v.flush_mode;
    beats = 0;
    e.data = line_of(v.addr);
    e.resp = v.resp;
    e.beats = v.miss ? 2 : 0;
    sb.push_back(e);
    send_ar(v.addr, ok);
    if (!ok) begin
      void'(sb.pop_front());
      return;
    end
    lat = 1;
    while (!r_valid_o && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!r_valid_o) begin
      chk("r_valid timeout", 0, 1);
      return;
    end
    if (!v.miss) chk("hit latency", lat, 2);
    chk("r_data", r_data_o, e.data);
    chk("r_resp", r_resp_o, e.resp);
    chk("mem beats", beats, e.beats);
    d0 = r_data_o;
    r0 = r_resp_o;
    repeat (v.bp) begin
      @(negedge clk);
      chk("backpressure stable", {r_valid_o, r_resp_o, r_data_o}, {1'b1, r0, d0});
    end
    r_ready_i = 1;
    @(negedge clk);
    r_ready_i = 0;
    chk("r_valid drop", r_valid_o, 0);
    chk("ar_ready idle", ar_ready_o, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    int n;
    add(32'h8000_0004, 0, 0, 1, 2'b00, 0);
    add(32'h8000_000C, 0, 0, 0, 2'b00, 0);
    add(32'h8000_0100, 0, 0, 1, 2'b00, 0);
    add(32'h8000_0000, 0, 0, 1, 2'b00, 0);
    add(32'h8000_0008, 0, 0, 0, 2'b00, 1);
    add(32'h8000_0210, 2, 0, 1, 2'b10, 0);
    add(32'h8000_0210, 0, 0, 1, 2'b00, 0);
    add(32'h8000_0214, 0, 0, 0, 2'b00, 0);
    add(32'h8000_0320, 0, 1, 1, 2'b00, 0);
    add(32'h8000_0320, 0, 0, 1, 2'b00, 0);
    add(32'h8000_0324, 0, 0, 0, 2'b00, 0);
    add(32'h8000_0324, 0, 2, 1, 2'b00, 0);
    add(32'h8000_0040, 1, 0, 1, 2'b10, 5);
    add(32'h8000_0040, 0, 0, 1, 2'b00, 5);
    add(32'h8000_0048, 0, 0, 0, 2'b00, 3);
    add(32'h8000_0550, 0, 3, 1, 2'b00, 0);
    add(32'h8000_0550, 0, 0, 1, 2'b00, 0);
    add(32'h8000_0554, 0, 0, 0, 2'b00, 0);
    repeat (2) @(negedge clk);
    chk("reset outputs", {ar_ready_o, r_valid_o, mem_req_o, mem_addr_o, r_resp_o, r_data_o[95:0]}, '0);
    chk("reset r_data hi", r_data_o[127:96], 0);
    rst_n = 1;
    @(negedge clk);
    chk("ar_ready after reset", ar_ready_o, 1);
    for (int i = 0; i < tbl.size(); i++) do_req(tbl[i]);
    block_mem = 1;
    cur_addr = 32'h8000_0660;
    send_ar(32'h8000_0660, ok);
    n = 0;
    while (!mem_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_req before reset", mem_req_o, 1);
    rst_n = 0;
    #1;
    chk("outputs in reset", {ar_ready_o, r_valid_o, mem_req_o, mem_addr_o, r_resp_o, r_data_o[95:0]}, '0);
    @(negedge clk);
    rv_t = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    rv_t = 0;
    chk("stale beat ignored", {r_valid_o, mem_req_o, ar_ready_o}, 3'b001);
    @(negedge clk);
    chk("still idle", {r_valid_o, mem_req_o, ar_ready_o}, 3'b001);
    block_mem = 0;
    tbl.delete();
    add(32'h8000_0660, 0, 0, 1, 2'b00, 0);
    add(32'h8000_0040, 0, 0, 1, 2'b00, 0);
    add(32'h8000_0668, 0, 0, 0, 2'b00, 2);
    for (int i = 0; i < tbl.size(); i++) do_req(tbl[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
